// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   - state_e   : controller FSM encoding (RUN/STALL/FLUSH)
//   - NOP_INSTR : instruction loaded into IF/ID on a flush
//   - PC_RESET  : fetch address after reset
//   - CTRL_W    : width of the decoded ID/EX control word
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_RESET  = 32'h0000_0000;
    localparam int          CTRL_W    = 10;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with redirect / hold / increment selection.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   branch_taken    : load branch_target (highest priority after reset)
//   branch_target   : redirect address
//   pc_write        : 0 holds the PC
//   pc              : current fetch address (registered)
//   pc4             : pc + 4, modulo 2^32 (combinational, shared with IF/ID)
module pc_reg
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        pc_write,
    output logic [31:0] pc,
    output logic [31:0] pc4
);

    logic [31:0] pc_q, pc_d;

    // 32-bit add wraps naturally: FFFFFFFC + 4 = 0
    assign pc4 = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_q;
        if (branch_taken)  pc_d = branch_target;
        else if (pc_write) pc_d = pc4;
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= PC_RESET;
        else     pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: owns PC (via pc_reg), the IF/ID register,
// the ID/EX control register and a RUN/STALL/FLUSH status FSM.
// Priority each cycle: rst > branch_taken > hazard request > normal advance.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   pc_write, ifid_write           : 0 = hold PC / hold IF/ID
//   ctrl_set_zero                  : 1 = bubble the ID/EX control word
//   branch_taken, branch_target    : redirect + flush from EX
//   imem_instr                     : instruction fetched at pc
//   id_ctrl                        : decoded control word from ID
//   pc, ifid_instr, ifid_pc4,
//   ifid_valid, idex_ctrl, state   : registered outputs
//   stall_cnt                      : bubble counter (only with STALL_COUNT_EN)
// Build option: define STALL_COUNT_EN to add the saturating stall_cnt counter.
module pipe_stall_ctrl
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_write,
    input  logic              ifid_write,
    input  logic              ctrl_set_zero,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       imem_instr,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [31:0]       pc,
    output logic [31:0]       ifid_instr,
    output logic [31:0]       ifid_pc4,
    output logic              ifid_valid,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic [1:0]        state
`ifdef STALL_COUNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    logic [31:0]       pc4;
    logic [31:0]       ifid_instr_q, ifid_pc4_q;
    logic              ifid_valid_q;
    logic [CTRL_W-1:0] idex_ctrl_q;
    state_e            state_q, state_d;
    logic              hazard;

    assign hazard = !pc_write || !ifid_write || ctrl_set_zero;

    pc_reg u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_write      (pc_write),
        .pc            (pc),
        .pc4           (pc4)
    );

    // IF/ID and ID/EX registers. ID/EX keeps loading id_ctrl while PC or
    // IF/ID is held; only ctrl_set_zero or a flush bubbles it.
    always_ff @(posedge clk) begin
        if (rst || branch_taken) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
            idex_ctrl_q  <= '0;
        end else begin
            if (ifid_write) begin
                ifid_instr_q <= imem_instr;
                ifid_pc4_q   <= pc4;
                ifid_valid_q <= 1'b1;
            end
            idex_ctrl_q <= ctrl_set_zero ? '0 : id_ctrl;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // FSM: next state. Every state goes to FLUSH on a branch and to STALL on
    // a hazard; otherwise everything returns to RUN.
    always_comb begin
        state_d = ST_RUN;
        if (branch_taken) state_d = ST_FLUSH;
        else if (hazard)  state_d = ST_STALL;
    end

    // FSM: outputs
    always_comb begin
        state = state_q;
    end

    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;
    assign idex_ctrl  = idex_ctrl_q;

`ifdef STALL_COUNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= 16'h0;
        else if (ctrl_set_zero && !branch_taken && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst, pc_write, ifid_write, ctrl_set_zero, branch_taken;
    logic [31:0] branch_target, imem_instr;
    logic [9:0]  id_ctrl;
    logic [31:0] pc, ifid_instr, ifid_pc4;
    logic        ifid_valid;
    logic [9:0]  idex_ctrl;
    logic [1:0]  state;
`ifdef STALL_COUNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ctrl_set_zero (ctrl_set_zero),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_instr    (imem_instr),
        .id_ctrl       (id_ctrl),
        .pc            (pc),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid),
        .idex_ctrl     (idex_ctrl),
        .state         (state)
`ifdef STALL_COUNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pw, input logic iw, input logic cz, input logic bt,
                         input logic [31:0] tgt);
        pc_write = pw; ifid_write = iw; ctrl_set_zero = cz;
        branch_taken = bt; branch_target = tgt;
    endtask

    task automatic cnt_chk(input string tag, input int exp);
`ifdef STALL_COUNT_EN
        chk(tag, {16'h0, stall_cnt}, exp[31:0]);
`else
        if (exp < 0) chk(tag, 32'h0, 32'h1);
`endif
    endtask

    initial begin
        rst = 1'b1; imem_instr = 32'h8C22_0004; id_ctrl = 10'h155;
        drive(1, 1, 0, 0, 32'h0);
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_idex", {22'h0, idex_ctrl}, 32'h0);
        chk("rst_state", {30'h0, state}, 32'h0);
        cnt_chk("rst_cnt", 0);

        // free run: 3 cycles
        rst = 1'b0;
        step(); chk("run1_pc", pc, 32'h4);
        step(); chk("run2_pc", pc, 32'h8);
        step();
        chk("run3_pc", pc, 32'hC);
        chk("run3_pc4", ifid_pc4, 32'hC);
        chk("run3_valid", {31'h0, ifid_valid}, 32'h1);
        chk("run3_state", {30'h0, state}, 32'h0);
        chk("run3_idex", {22'h0, idex_ctrl}, 32'h155);

        // back to pc=8, then full stall for two cycles
        rst = 1'b1; step(); rst = 1'b0;
        step(); step();
        chk("pre_pc", pc, 32'h8);
        imem_instr = 32'h1111_1111;
        drive(0, 0, 1, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stl_pc", pc, 32'h8);
            chk("stl_pc4", ifid_pc4, 32'h8);
            chk("stl_instr", ifid_instr, 32'h8C22_0004);
            chk("stl_idex", {22'h0, idex_ctrl}, 32'h0);
            chk("stl_state", {30'h0, state}, 32'h1);
        end
        drive(1, 1, 0, 0, 32'h0);
        step();
        chk("rel_pc", pc, 32'hC);
        chk("rel_state", {30'h0, state}, 32'h0);
        chk("rel_instr", ifid_instr, 32'h1111_1111);
        chk("rel_idex", {22'h0, idex_ctrl}, 32'h155);
        cnt_chk("rel_cnt", 2);

        // branch wins over a simultaneous stall request
        drive(0, 0, 1, 1, 32'h100);
        step();
        chk("br_pc", pc, 32'h100);
        chk("br_instr", ifid_instr, 32'h0);
        chk("br_valid", {31'h0, ifid_valid}, 32'h0);
        chk("br_idex", {22'h0, idex_ctrl}, 32'h0);
        chk("br_state", {30'h0, state}, 32'h2);
        cnt_chk("br_cnt", 2);
        drive(1, 1, 0, 0, 32'h0);
        step();
        chk("fl_state", {30'h0, state}, 32'h0);
        chk("fl_pc", pc, 32'h104);
        chk("fl_pc4", ifid_pc4, 32'h104);
        chk("fl_valid", {31'h0, ifid_valid}, 32'h1);

        // PC wrap
        drive(1, 1, 0, 1, 32'hFFFF_FFFC);
        step();
        chk("wr0_pc", pc, 32'hFFFF_FFFC);
        drive(1, 1, 0, 0, 32'h0);
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_pc4", ifid_pc4, 32'h0);

        // bubble only: pc and IF/ID still advance
        id_ctrl = 10'h3FF; imem_instr = 32'h2222_2222;
        drive(1, 1, 1, 0, 32'h0);
        step();
        chk("cz_pc", pc, 32'h4);
        chk("cz_pc4", ifid_pc4, 32'h4);
        chk("cz_instr", ifid_instr, 32'h2222_2222);
        chk("cz_idex", {22'h0, idex_ctrl}, 32'h0);
        chk("cz_state", {30'h0, state}, 32'h1);
        cnt_chk("cz_cnt", 3);

        // IF/ID hold only: pc advances, ID/EX passes id_ctrl through
        imem_instr = 32'h3333_3333;
        drive(1, 0, 0, 0, 32'h0);
        step();
        chk("iw_pc", pc, 32'h8);
        chk("iw_instr", ifid_instr, 32'h2222_2222);
        chk("iw_pc4", ifid_pc4, 32'h4);
        chk("iw_idex", {22'h0, idex_ctrl}, 32'h3FF);
        chk("iw_state", {30'h0, state}, 32'h1);

        // PC hold only: IF/ID still loads
        drive(0, 1, 0, 0, 32'h0);
        step();
        chk("pw_pc", pc, 32'h8);
        chk("pw_instr", ifid_instr, 32'h3333_3333);
        chk("pw_pc4", ifid_pc4, 32'hC);

        // two more bubbles -> count 5, then reset mid-stall
        drive(0, 0, 1, 0, 32'h0);
        step(); step();
        cnt_chk("pre_rst_cnt", 5);
        chk("pre_rst_state", {30'h0, state}, 32'h1);
        rst = 1'b1;
        drive(0, 0, 1, 1, 32'h40);
        step();
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_instr", ifid_instr, 32'h0);
        chk("mrst_pc4", ifid_pc4, 32'h0);
        chk("mrst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("mrst_idex", {22'h0, idex_ctrl}, 32'h0);
        chk("mrst_state", {30'h0, state}, 32'h0);
        cnt_chk("mrst_cnt", 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port pc_write, input, 1, hazard request; 0 = hold PC.
REQ-004 SHALL have port ifid_write, input, 1, hazard request; 0 = hold the IF/ID register.
REQ-005 SHALL have port ctrl_set_zero, input, 1, hazard request; 1 = bubble the ID/EX control.
REQ-006 SHALL have port branch_taken, input, 1, redirect plus flush request from EX.
REQ-007 SHALL have port branch_target, input, 32, redirect address.
REQ-008 SHALL have port imem_instr, input, 32, instruction fetched at pc.
REQ-009 SHALL have port id_ctrl, input, 10, decoded control word from ID.
REQ-010 SHALL have port pc, output, 32, current fetch address.
REQ-011 SHALL have ports ifid_instr, ifid_pc4, output, 32 each, IF/ID register contents.
REQ-012 SHALL have port ifid_valid, output, 1, IF/ID holds a real instruction.
REQ-013 SHALL have port idex_ctrl, output, 10, registered ID/EX control word.
REQ-014 SHALL have port state, output, 2, FSM state: RUN=0, STALL=1, FLUSH=2.
REQ-015 SHALL have port stall_cnt, output, 16, present only with STALL_COUNT_EN.

Function
REQ-016 Priority per cycle SHALL be rst > branch_taken > hazard (pc_write/ifid_write/ctrl_set_zero) > normal advance.
REQ-017 Normal advance SHALL be: pc<=pc+4; ifid_instr<=imem_instr; ifid_pc4<=pc+4; ifid_valid<=1; idex_ctrl<=id_ctrl.
REQ-018 PC arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC+4 = 32'h0.
REQ-019 branch_taken=1 SHALL set pc<=branch_target, ifid_instr<=32'h0, ifid_pc4<=0, ifid_valid<=0, idex_ctrl<=0, and SHALL ignore all hazard inputs that cycle.
REQ-020 pc_write=0 SHALL hold pc, independent of ifid_write.
REQ-021 ifid_write=0 SHALL hold ifid_instr, ifid_pc4 and ifid_valid.
REQ-022 ctrl_set_zero=1 SHALL load idex_ctrl<=0; otherwise idex_ctrl<=id_ctrl, including while pc or IF/ID is held.
REQ-023 A hazard condition SHALL be pc_write=0 or ifid_write=0 or ctrl_set_zero=1.
REQ-024 FSM transitions SHALL be:
  - any state -> FLUSH on branch_taken;
  - RUN/FLUSH -> STALL on a hazard condition;
  - STALL -> RUN when the hazard clears;
  - FLUSH -> RUN otherwise.
REQ-025 Stall duration SHALL be unbounded; pc and IF/ID SHALL remain held for as long as the request persists.
REQ-026 All outputs SHALL be registered; the effect of any input SHALL be visible exactly one clock later.

Reset
REQ-027 rst=1 at a clock edge SHALL set pc=0, ifid_instr=0, ifid_pc4=0, ifid_valid=0, idex_ctrl=0, state=RUN, stall_cnt=0.
REQ-028 rst SHALL override a simultaneous branch_taken or hazard, including mid-stall or mid-flush.

Configuration
REQ-029 With STALL_COUNT_EN defined, stall_cnt SHALL increment by 1 on each non-reset cycle in which ctrl_set_zero=1 and branch_taken=0, saturating at 16'hFFFF.
REQ-030 Without STALL_COUNT_EN, the stall_cnt port and its counter SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-031 Shared package pipe_pkg SHALL hold:
  - FSM state encoding;
  - NOP_INSTR=32'h0;
  - PC_RESET=32'h0;
  - CTRL_W=10.
REQ-032 The PC register, with its hold/redirect/increment mux, SHALL be sub-module pc_reg; all other logic SHALL stay in pipe_stall_ctrl.

Verification
REQ-033 Reset then 3 free cycles, imem_instr=32'h8C220004 -> pc 0,4,8,12; ifid_pc4=12, ifid_valid=1, state=RUN.
REQ-034 At pc=8, pc_write=0, ifid_write=0, ctrl_set_zero=1 for 2 cycles -> pc=8 and ifid held for both cycles, idex_ctrl=0, state=STALL; after release pc=12 and state=RUN; stall_cnt=2 with STALL_COUNT_EN.
REQ-035 branch_taken=1 with branch_target=32'h00000100 and a simultaneous stall request -> pc=32'h100, ifid_instr=0, ifid_valid=0, idex_ctrl=0, state=FLUSH, then RUN next cycle.
REQ-036 pc=32'hFFFFFFFC with normal advance -> pc=0 and ifid_pc4=0.
REQ-037 rst=1 asserted during STALL with stall_cnt=5 -> all outputs at reset values next cycle and stall_cnt=0.
REQ-038 ctrl_set_zero=1 alone, id_ctrl=10'h3FF -> pc and ifid advance, idex_ctrl=0, state=STALL.
